// File: rtl/txc_mport_pkg.sv
// Shared types for the multi-port transmit controller: lane states, segment markers, port index width.
package txc_mport_pkg;

   typedef enum logic [1:0] {
      LANE_IDLE = 2'd0,
      LANE_FWD  = 2'd1,
      LANE_DROP = 2'd2
   } txc_lane_st_e;

   typedef struct packed {
      logic sop;
      logic eop;
      logic err;
   } txc_mark_t;

   function automatic int unsigned txc_port_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/txc_mport_lane.sv
// One EPL port lane: packet-atomic input FSM, segment FIFO, credit counter, done/drop/error flags.
module txc_mport_lane
   import txc_mport_pkg::*;
#(
   parameter  int unsigned DATA_W      = 512,
   parameter  int unsigned FIFO_DEPTH  = 8,
   parameter  int unsigned MAX_CREDITS = 16,
   localparam int unsigned CREDIT_W    = $clog2(MAX_CREDITS + 1),
   localparam int unsigned AW          = $clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic              acc_i,
   input  logic              sop_i,
   input  logic              eop_i,
   input  logic              err_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              credit_ret_i,
   input  logic              ext_err_i,
   output logic              full_c_o,
   output logic              discard_c_o,
   output logic              valid_c_o,
   output logic [DATA_W-1:0] data_c_o,
   output logic              sop_c_o,
   output logic              eop_c_o,
   output logic              err_c_o,
   output logic              done_c_o,
   output logic              drop_o,
   output logic              err_sticky_o
);

   txc_lane_st_e        st_q, st_d;
   logic [AW:0]         wr_q, wr_d, rd_q, rd_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                drop_q, drop_d;
   logic                err_q, err_d;
   logic                push, pop, empty;
   logic                proto_err, credit_err;
   logic [DATA_W-1:0]   data_mem_q [FIFO_DEPTH];
   txc_mark_t           mark_mem_q [FIFO_DEPTH];
   txc_mark_t           head;

   // Pointer wrap bit distinguishes full from empty
   assign empty    = (wr_q == rd_q);
   assign full_c_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

   // Segments that will be thrown away never need FIFO space
   assign discard_c_o = (st_q == LANE_DROP) || ((st_q == LANE_IDLE) && sop_i && !en_i);

   assign pop       = !empty && (credit_q != '0);
   assign head      = mark_mem_q[rd_q[AW-1:0]];
   assign valid_c_o = pop;
   assign data_c_o  = pop ? data_mem_q[rd_q[AW-1:0]] : '0;
   assign sop_c_o   = pop && head.sop;
   assign eop_c_o   = pop && head.eop;
   assign err_c_o   = pop && head.err;
   assign done_c_o  = pop && head.eop;

   assign drop_o       = drop_q;
   assign err_sticky_o = err_q;

   // Input FSM: enable is sampled only at a packet's SOP
   always_comb begin
      st_d      = st_q;
      push      = 1'b0;
      drop_d    = 1'b0;
      proto_err = 1'b0;
      if (acc_i) begin
         if (sop_i && (st_q != LANE_DROP)) begin
            proto_err = (st_q == LANE_FWD);
            if (en_i) begin
               push = 1'b1;
               st_d = eop_i ? LANE_IDLE : LANE_FWD;
            end else begin
               drop_d = 1'b1;
               st_d   = eop_i ? LANE_IDLE : LANE_DROP;
            end
         end else begin
            case (st_q)
               LANE_FWD: begin
                  push = 1'b1;
                  if (eop_i) st_d = LANE_IDLE;
               end
               LANE_DROP: begin
                  proto_err = sop_i;
                  if (eop_i) st_d = LANE_IDLE;
               end
               default: proto_err = 1'b1;
            endcase
         end
      end
   end

   // Credit counter; a return with nothing to absorb it saturates and flags an error
   always_comb begin
      credit_d   = credit_q;
      credit_err = 1'b0;
      if (pop && !credit_ret_i) begin
         credit_d = credit_q - CREDIT_W'(1);
      end else if (!pop && credit_ret_i) begin
         if (credit_q == CREDIT_W'(MAX_CREDITS)) credit_err = 1'b1;
         else                                    credit_d   = credit_q + CREDIT_W'(1);
      end
   end

   always_comb begin
      wr_d  = wr_q + (AW+1)'(push);
      rd_d  = rd_q + (AW+1)'(pop);
      err_d = err_q || proto_err || credit_err || ext_err_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= LANE_IDLE;
         wr_q     <= '0;
         rd_q     <= '0;
         credit_q <= CREDIT_W'(MAX_CREDITS);
         drop_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         st_q     <= st_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         credit_q <= credit_d;
         drop_q   <= drop_d;
         err_q    <= err_d;
      end
   end

   // Storage needs no reset: pointers define what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem_q[wr_q[AW-1:0]] <= data_i;
         mark_mem_q[wr_q[AW-1:0]] <= '{sop: sop_i, eop: eop_i, err: err_i};
      end
   end

endmodule

// File: rtl/txc_mport.sv
// N-port transmit controller: steers port-tagged segments into per-port lanes and packs lane outputs.
module txc_mport
   import txc_mport_pkg::*;
#(
   parameter  int unsigned NUM_PORTS   = 4,
   parameter  int unsigned DATA_W      = 512,
   parameter  int unsigned FIFO_DEPTH  = 8,
   parameter  int unsigned MAX_CREDITS = 16,
   localparam int unsigned PORT_W      = txc_port_w(NUM_PORTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        cfg_port_en,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [PORT_W-1:0]           in_port,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        in_sop,
   input  logic                        in_eop,
   input  logic                        in_err,
   output logic [NUM_PORTS-1:0]        epl_valid,
   output logic [NUM_PORTS*DATA_W-1:0] epl_data,
   output logic [NUM_PORTS-1:0]        epl_sop,
   output logic [NUM_PORTS-1:0]        epl_eop,
   output logic [NUM_PORTS-1:0]        epl_err,
   input  logic [NUM_PORTS-1:0]        epl_credit_ret,
   output logic [NUM_PORTS-1:0]        lcm_pkt_done,
   output logic [NUM_PORTS-1:0]        drop_pkt,
   output logic [NUM_PORTS-1:0]        err_sticky
);

   logic                 in_range;
   logic                 oor_err;
   logic [NUM_PORTS-1:0] lane_full;
   logic [NUM_PORTS-1:0] lane_discard;
   logic [NUM_PORTS-1:0] lane_acc;
   logic [NUM_PORTS-1:0] ext_err;

   assign in_range = (32'(in_port) < NUM_PORTS);
   assign oor_err  = in_valid && !in_range;
   assign ext_err  = NUM_PORTS'(oor_err);

   // Out-of-range segments are swallowed; otherwise stall only on a full lane that would keep the segment
   always_comb begin
      in_ready = 1'b1;
      if (in_range) in_ready = !lane_full[in_port] || lane_discard[in_port];
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
      assign lane_acc[p] = in_valid && in_ready && in_range && (in_port == PORT_W'(p));

      txc_mport_lane #(
         .DATA_W      (DATA_W),
         .FIFO_DEPTH  (FIFO_DEPTH),
         .MAX_CREDITS (MAX_CREDITS)
      ) u_lane (
         .clk          (clk),
         .rst          (rst),
         .en_i         (cfg_port_en[p]),
         .acc_i        (lane_acc[p]),
         .sop_i        (in_sop),
         .eop_i        (in_eop),
         .err_i        (in_err),
         .data_i       (in_data),
         .credit_ret_i (epl_credit_ret[p]),
         .ext_err_i    (ext_err[p]),
         .full_c_o     (lane_full[p]),
         .discard_c_o  (lane_discard[p]),
         .valid_c_o    (epl_valid[p]),
         .data_c_o     (epl_data[p*DATA_W +: DATA_W]),
         .sop_c_o      (epl_sop[p]),
         .eop_c_o      (epl_eop[p]),
         .err_c_o      (epl_err[p]),
         .done_c_o     (lcm_pkt_done[p]),
         .drop_o       (drop_pkt[p]),
         .err_sticky_o (err_sticky[p])
      );
   end

endmodule

// File: tb/tb_txc_mport.sv
// Bench for txc_mport: directed scenarios plus random traffic against a queue-based port model.
module tb_txc_mport;

   localparam int unsigned NP = 4;
   localparam int unsigned DW = 512;
   localparam int unsigned FD = 8;
   localparam int unsigned MC = 16;
   localparam int unsigned PW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [NP-1:0]    cfg_port_en;
   logic             in_valid;
   logic             in_ready;
   logic [PW-1:0]    in_port;
   logic [DW-1:0]    in_data;
   logic             in_sop, in_eop, in_err;
   logic [NP-1:0]    epl_valid;
   logic [NP*DW-1:0] epl_data;
   logic [NP-1:0]    epl_sop, epl_eop, epl_err;
   logic [NP-1:0]    epl_credit_ret;
   logic [NP-1:0]    lcm_pkt_done, drop_pkt, err_sticky;

   always #5 clk = ~clk;

   txc_mport #(.NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(FD), .MAX_CREDITS(MC)) dut (
      .clk(clk), .rst(rst), .cfg_port_en(cfg_port_en),
      .in_valid(in_valid), .in_ready(in_ready), .in_port(in_port), .in_data(in_data),
      .in_sop(in_sop), .in_eop(in_eop), .in_err(in_err),
      .epl_valid(epl_valid), .epl_data(epl_data), .epl_sop(epl_sop), .epl_eop(epl_eop),
      .epl_err(epl_err), .epl_credit_ret(epl_credit_ret), .lcm_pkt_done(lcm_pkt_done),
      .drop_pkt(drop_pkt), .err_sticky(err_sticky)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [DW-1:0] d;
      bit            s;
      bit            e;
      bit            r;
   } seg_t;

   seg_t mq [NP][$];
   int   m_cred   [NP];
   bit   m_in_pkt [NP];   // inside a forwarded packet
   bit   m_drop   [NP];   // inside a dropped packet
   bit   m_err    [NP];
   bit   m_pulse  [NP];
   bit   live = 1'b0;
   bit   m_acc = 1'b0;

   int checks = 0;
   int errors = 0;
   int sent_cnt [NP];
   int done_cnt [NP];
   int drop_cnt [NP];
   int extra_waits = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit exp_ready();
      int p;
      p = int'(in_port);
      if (p >= NP) return 1'b1;
      return (mq[p].size() < FD) || m_drop[p] ||
             (!m_in_pkt[p] && !m_drop[p] && in_sop && !cfg_port_en[p]);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int q = 0; q < NP; q++) begin
            mq[q].delete();
            m_cred[q] = MC; m_in_pkt[q] = 0; m_drop[q] = 0; m_err[q] = 0; m_pulse[q] = 0;
         end
         m_acc = 0;
         live  = 1;
      end else if (live) begin
         bit rdy;
         int p;
         rdy   = exp_ready();
         p     = int'(in_port);
         m_acc = in_valid && rdy;
         for (int q = 0; q < NP; q++) begin
            int snd;
            snd = (mq[q].size() > 0 && m_cred[q] > 0) ? 1 : 0;
            if (snd == 1) void'(mq[q].pop_front());
            m_cred[q] = m_cred[q] - snd + (epl_credit_ret[q] ? 1 : 0);
            if (m_cred[q] > MC) begin m_cred[q] = MC; m_err[q] = 1; end
            m_pulse[q] = 0;
         end
         if (m_acc && p < NP) begin
            seg_t sg;
            sg.d = in_data; sg.s = in_sop; sg.e = in_eop; sg.r = in_err;
            if (in_sop && !m_drop[p]) begin
               if (m_in_pkt[p]) m_err[p] = 1;
               if (cfg_port_en[p]) begin
                  mq[p].push_back(sg);
                  m_in_pkt[p] = !in_eop;
               end else begin
                  m_pulse[p]  = 1;
                  m_in_pkt[p] = 0;
                  m_drop[p]   = !in_eop;
               end
            end else if (m_drop[p]) begin
               if (in_sop) m_err[p] = 1;
               if (in_eop) m_drop[p] = 0;
            end else if (m_in_pkt[p]) begin
               mq[p].push_back(sg);
               if (in_eop) m_in_pkt[p] = 0;
            end else begin
               m_err[p] = 1;
            end
         end else if (m_acc) begin
            m_err[0] = 1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the clock edge
   always @(negedge clk) begin
      if (live) begin
         chk("in_ready", DW'(in_ready), DW'(exp_ready()));
         for (int p = 0; p < NP; p++) begin
            bit   hv;
            seg_t h;
            hv = (mq[p].size() > 0) && (m_cred[p] > 0);
            h  = '{d: '0, s: 0, e: 0, r: 0};
            if (hv) h = mq[p][0];
            chk($sformatf("epl_valid[%0d]", p), DW'(epl_valid[p]), DW'(hv));
            chk($sformatf("epl_data[%0d]", p), epl_data[p*DW +: DW], h.d);
            chk($sformatf("epl_sop[%0d]", p), DW'(epl_sop[p]), DW'(h.s));
            chk($sformatf("epl_eop[%0d]", p), DW'(epl_eop[p]), DW'(h.e));
            chk($sformatf("epl_err[%0d]", p), DW'(epl_err[p]), DW'(h.r));
            chk($sformatf("lcm_pkt_done[%0d]", p), DW'(lcm_pkt_done[p]), DW'(hv && h.e));
            chk($sformatf("drop_pkt[%0d]", p), DW'(drop_pkt[p]), DW'(m_pulse[p]));
            chk($sformatf("err_sticky[%0d]", p), DW'(err_sticky[p]), DW'(m_err[p]));
            if (epl_valid[p] === 1'b1)    sent_cnt[p]++;
            if (lcm_pkt_done[p] === 1'b1) done_cnt[p]++;
            if (drop_pkt[p] === 1'b1)     drop_cnt[p]++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic clr_cnt();
      for (int p = 0; p < NP; p++) begin sent_cnt[p] = 0; done_cnt[p] = 0; drop_cnt[p] = 0; end
   endtask

   task automatic send_seg(input int p, input bit s, input bit e);
      int n;
      in_valid = 1; in_port = PW'(p); in_sop = s; in_eop = e;
      in_err = e && ($urandom_range(0, 3) == 0);
      in_data = rnd_data();
      n = 0;
      do begin tick(); n++; end while (!m_acc && n < 100);
      if (!m_acc) chk("accept_timeout", DW'(0), DW'(1));
      extra_waits += n - 1;
      in_valid = 0;
   endtask

   // Return credits one at a time until the port is back at its reset allowance
   task automatic topup(input int p);
      int n;
      n = 0;
      while (mq[p].size() > 0 && n < 200) begin epl_credit_ret[p] = 1; tick(); n++; end
      epl_credit_ret[p] = 0;
      while (m_cred[p] < MC && n < 200) begin
         epl_credit_ret[p] = 1; tick(); epl_credit_ret[p] = 0; n++;
      end
      if (n >= 200) chk("topup_timeout", DW'(0), DW'(1));
   endtask

   initial begin
      bit open_r [NP];
      rst = 1; cfg_port_en = '1; in_valid = 0; in_port = '0; in_data = '0;
      in_sop = 0; in_eop = 0; in_err = 0; epl_credit_ret = '0;
      tick(); tick();
      chk("rst_in_ready", DW'(in_ready), DW'(1));
      chk("rst_epl_valid", DW'(epl_valid), DW'(0));
      chk("rst_err_sticky", DW'(err_sticky), DW'(0));
      rst = 0;
      tick();

      // 1: three-segment packet to port 2
      clr_cnt();
      send_seg(2, 1, 0);
      chk("s1_latency", DW'(epl_valid[2]), DW'(1));
      send_seg(2, 0, 0);
      send_seg(2, 0, 1);
      repeat (3) tick();
      chk("s1_sent", DW'(sent_cnt[2]), DW'(3));
      chk("s1_done", DW'(done_cnt[2]), DW'(1));
      chk("s1_credit", DW'(m_cred[2]), DW'(13));
      topup(2);

      // 2: credit exhaustion then backpressure on port 0
      clr_cnt();
      for (int i = 0; i < 20; i++) send_seg(0, 1, 1);
      repeat (4) tick();
      chk("s2_sent16", DW'(sent_cnt[0]), DW'(16));
      chk("s2_held4", DW'(mq[0].size()), DW'(4));
      epl_credit_ret[0] = 1; repeat (4) tick(); epl_credit_ret[0] = 0;
      repeat (3) tick();
      chk("s2_sent20", DW'(sent_cnt[0]), DW'(20));
      for (int i = 0; i < 8; i++) send_seg(0, 1, 1);
      in_valid = 1; in_port = 0; in_sop = 1; in_eop = 1; in_data = rnd_data();
      tick(); tick();
      chk("s2_backpressure", DW'(in_ready), DW'(0));
      epl_credit_ret[0] = 1;
      begin
         int n;
         n = 0;
         do begin tick(); n++; end while (!m_acc && n < 50);
         if (!m_acc) chk("s2_release_timeout", DW'(0), DW'(1));
      end
      in_valid = 0;
      topup(0);
      chk("s2_sent_total", DW'(sent_cnt[0]), DW'(29));
      chk("s2_no_err", DW'(err_sticky[0]), DW'(0));

      // 3: disabled port drops a whole packet even if re-enabled mid-packet
      clr_cnt(); extra_waits = 0;
      cfg_port_en[1] = 0;
      send_seg(1, 1, 0); send_seg(1, 0, 0);
      cfg_port_en[1] = 1;
      send_seg(1, 0, 0); send_seg(1, 0, 1);
      repeat (2) tick();
      chk("s3_drop_once", DW'(drop_cnt[1]), DW'(1));
      chk("s3_none_sent", DW'(sent_cnt[1]), DW'(0));
      chk("s3_no_stall", DW'(extra_waits), DW'(0));
      send_seg(1, 1, 0); send_seg(1, 0, 1);
      repeat (3) tick();
      chk("s3_next_fwd", DW'(sent_cnt[1]), DW'(2));
      topup(1);

      // 4: disable after SOP keeps current packet, drops the next
      clr_cnt();
      send_seg(3, 1, 0);
      cfg_port_en[3] = 0;
      send_seg(3, 0, 0); send_seg(3, 0, 1);
      send_seg(3, 1, 0); send_seg(3, 0, 1);
      repeat (3) tick();
      chk("s4_fwd3", DW'(sent_cnt[3]), DW'(3));
      chk("s4_drop1", DW'(drop_cnt[3]), DW'(1));
      cfg_port_en[3] = 1;
      topup(3);

      // 5: send+return at full credit is neutral; bare return overflows
      send_seg(0, 1, 1);
      epl_credit_ret[0] = 1; tick(); epl_credit_ret[0] = 0; tick();
      chk("s5_credit16", DW'(m_cred[0]), DW'(16));
      chk("s5_no_err", DW'(err_sticky[0]), DW'(0));
      epl_credit_ret[0] = 1; tick(); epl_credit_ret[0] = 0; tick();
      chk("s5_overflow_err", DW'(err_sticky[0]), DW'(1));
      chk("s5_credit_sat", DW'(m_cred[0]), DW'(16));

      // 6: all ports released together, then reset mid-stream
      rst = 1; tick(); rst = 0; tick();
      chk("s6_rst_err", DW'(err_sticky), DW'(0));
      for (int i = 0; i < 64; i++) send_seg(i % NP, 1, 1);
      for (int i = 0; i < NP; i++) send_seg(i, 1, 1);
      repeat (2) tick();
      chk("s6_held", DW'(epl_valid), DW'(0));
      epl_credit_ret = '1; tick(); epl_credit_ret = '0;
      chk("s6_all_valid", DW'(epl_valid), DW'(4'hF));
      chk("s6_all_done", DW'(lcm_pkt_done), DW'(4'hF));
      tick();
      epl_credit_ret = '1;
      for (int i = 0; i < 6; i++) send_seg(i % NP, 1, 1);
      in_valid = 1; in_port = 2; in_sop = 1; in_eop = 0;
      rst = 1; tick();
      chk("s6_rst_valid", DW'(epl_valid), DW'(0));
      chk("s6_rst_done", DW'(lcm_pkt_done), DW'(0));
      chk("s6_rst_drop", DW'(drop_pkt), DW'(0));
      chk("s6_rst_data", epl_data[DW-1:0], DW'(0));
      rst = 0; in_valid = 0; epl_credit_ret = '0;
      tick();

      // random traffic
      for (int p = 0; p < NP; p++) open_r[p] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int p;
         int ret_pct;
         p = int'($urandom_range(0, NP-1));
         ret_pct = (cyc < 1500) ? 10 : 50;
         in_valid = ($urandom_range(0, 99) < 70);
         in_port  = PW'(p);
         in_sop   = !open_r[p];
         if ($urandom_range(0, 99) < 3) in_sop = !in_sop;
         in_eop   = ($urandom_range(0, 2) == 0);
         in_err   = in_eop && ($urandom_range(0, 7) == 0);
         in_data  = rnd_data();
         for (int q = 0; q < NP; q++) begin
            epl_credit_ret[q] = (($urandom_range(0, 99) < ret_pct) && m_cred[q] < MC) ||
                                ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 99) < 2) cfg_port_en[q] = !cfg_port_en[q];
         end
         rst = ($urandom_range(0, 999) == 0);
         tick();
         for (int q = 0; q < NP; q++) open_r[q] = m_in_pkt[q] || m_drop[q];
      end
      in_valid = 0; rst = 0; epl_credit_ret = '0;
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
